// File: rtl/systolic_ctrl_pkg.sv
// Shared configuration for the systolic array sequencer: array geometry,
// derived widths and the controller state type.
package systolic_ctrl_pkg;

  localparam int SYS_ROWS   = 4;
  localparam int SYS_COLS   = 4;
  localparam int CTRL_VEC_W = 8;
  localparam int WADDR_W    = $clog2(SYS_ROWS);
  localparam int O_LAT      = SYS_ROWS;
  // Wide enough that a full-length job never wraps any sequencing counter.
  localparam int CNT_W      = CTRL_VEC_W + $clog2(SYS_ROWS + SYS_COLS + O_LAT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SWITCH,
    STREAM,
    DRAIN
  } ctrl_state_e;

endpackage

// File: rtl/systolic_ctrl_if.sv
// Job request and buffer/array strobe bundle between the sequencer (slave)
// and whoever issues jobs and watches the strobes (master).
interface systolic_ctrl_if;
  import systolic_ctrl_pkg::*;

  logic                                  start;
  logic [CTRL_VEC_W-1:0]                 num_vec;
  logic                                  reuse_w;
  logic                                  busy;
  logic                                  done;
  logic                                  w_rd_en;
  logic [WADDR_W-1:0]                    w_rd_addr;
  logic [SYS_COLS-1:0]                   wfetch;
  logic                                  switch;
  logic [SYS_ROWS-1:0]                   a_rd_en;
  logic [SYS_ROWS-1:0][CTRL_VEC_W-1:0]   a_rd_addr;
  logic [SYS_ROWS-1:0]                   if_en;
  logic [SYS_COLS-1:0]                   o_valid;
  logic [SYS_COLS-1:0][CTRL_VEC_W-1:0]   o_addr;

  modport master (
    output start, num_vec, reuse_w,
    input  busy, done, w_rd_en, w_rd_addr, wfetch, switch,
    input  a_rd_en, a_rd_addr, if_en, o_valid, o_addr
  );

  modport slave (
    input  start, num_vec, reuse_w,
    output busy, done, w_rd_en, w_rd_addr, wfetch, switch,
    output a_rd_en, a_rd_addr, if_en, o_valid, o_addr
  );

endinterface

// File: rtl/systolic_ctrl_skew_line.sv
// Skew line: N-tap shift register of {valid, index}; tap i is the input
// delayed by i+1 cycles. Used for both the row and the column skew.
module systolic_ctrl_skew_line #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [W-1:0]        in_idx,
  output logic [N-1:0]        tap_valid,
  output logic [N-1:0][W-1:0] tap_idx
);

  logic [N-1:0]        valid_reg;
  logic [N-1:0][W-1:0] idx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      idx_reg   <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      idx_reg[0]   <= in_idx;
      for (int i = 1; i < N; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        idx_reg[i]   <= idx_reg[i-1];
      end
    end
  end

  assign tap_valid = valid_reg;
  assign tap_idx   = idx_reg;

endmodule

// File: rtl/systolic_ctrl.sv
// Systolic MAC array sequencer: weight load, switch, skewed activation
// streaming and result-column tagging per job, ending with a done pulse.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
(
  input logic            clk,
  input logic            rst,
  systolic_ctrl_if.slave bus
);

  localparam int VEC_W = CTRL_VEC_W;

  ctrl_state_e                      state_reg;
  logic [VEC_W-1:0]                 nv_reg;
  logic [VEC_W-1:0]                 nv_last_reg;
  logic [CNT_W-1:0]                 cnt_reg;
  logic [CNT_W-1:0]                 cnt_next;
  logic [CNT_W-1:0]                 stream_last;
  logic                             busy_reg;
  logic                             done_reg;
  logic                             w_rd_en_reg;
  logic [WADDR_W-1:0]               w_rd_addr_reg;
  logic                             wfetch_reg;
  logic                             switch_reg;
  logic                             issue_valid_reg;
  logic [VEC_W-1:0]                 issue_idx_reg;
  logic [SYS_ROWS-1:0]              row_valid;
  logic [SYS_ROWS-1:0][VEC_W-1:0]   row_idx;
  logic [SYS_COLS-1:0]              col_valid;
  logic [SYS_COLS-1:0][VEC_W-1:0]   col_idx;
  logic                             last_out;

  assign cnt_next    = cnt_reg + CNT_W'(1);
  assign stream_last = CNT_W'(nv_reg) + CNT_W'(SYS_ROWS - 2);
  assign last_out    = col_valid[SYS_COLS-1] && (col_idx[SYS_COLS-1] == nv_last_reg);

  // Outputs are computed one cycle ahead so every strobe leaves a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      nv_reg          <= '0;
      nv_last_reg     <= '0;
      cnt_reg         <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      w_rd_en_reg     <= 1'b0;
      w_rd_addr_reg   <= '0;
      wfetch_reg      <= 1'b0;
      switch_reg      <= 1'b0;
      issue_valid_reg <= 1'b0;
      issue_idx_reg   <= '0;
    end else begin
      switch_reg <= 1'b0;
      done_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            nv_reg      <= bus.num_vec;
            nv_last_reg <= bus.num_vec - VEC_W'(1);
            busy_reg    <= 1'b1;
            cnt_reg     <= '0;
            if (bus.num_vec == '0) begin
              state_reg <= DRAIN;
            end else if (bus.reuse_w) begin
              state_reg       <= STREAM;
              issue_valid_reg <= 1'b1;
              issue_idx_reg   <= '0;
            end else begin
              state_reg     <= LOAD_W;
              w_rd_en_reg   <= 1'b1;
              w_rd_addr_reg <= WADDR_W'(SYS_ROWS - 1);
            end
          end
        end
        LOAD_W: begin
          if (cnt_reg == CNT_W'(SYS_ROWS)) begin
            state_reg  <= SWITCH;
            cnt_reg    <= '0;
            wfetch_reg <= 1'b0;
            switch_reg <= 1'b1;
          end else begin
            cnt_reg    <= cnt_next;
            // Buffer data lands one cycle after each read, so wfetch trails w_rd_en.
            wfetch_reg <= 1'b1;
            if (cnt_next < CNT_W'(SYS_ROWS)) begin
              w_rd_en_reg   <= 1'b1;
              w_rd_addr_reg <= WADDR_W'(SYS_ROWS - 2) - cnt_reg[WADDR_W-1:0];
            end else begin
              w_rd_en_reg   <= 1'b0;
              w_rd_addr_reg <= '0;
            end
          end
        end
        SWITCH: begin
          state_reg       <= STREAM;
          cnt_reg         <= '0;
          issue_valid_reg <= 1'b1;
          issue_idx_reg   <= '0;
        end
        STREAM: begin
          if (cnt_reg == stream_last) begin
            state_reg       <= DRAIN;
            cnt_reg         <= '0;
            issue_valid_reg <= 1'b0;
            issue_idx_reg   <= '0;
          end else begin
            cnt_reg <= cnt_next;
            if (cnt_next < CNT_W'(nv_reg)) begin
              issue_valid_reg <= 1'b1;
              issue_idx_reg   <= cnt_next[VEC_W-1:0];
            end else begin
              issue_valid_reg <= 1'b0;
              issue_idx_reg   <= '0;
            end
          end
        end
        DRAIN: begin
          if (done_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if ((nv_reg == '0) || last_out) begin
            done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Row line: tap r-1 is the read strobe of row r, tap r is row r's if_en.
  systolic_ctrl_skew_line #(
    .N (SYS_ROWS),
    .W (VEC_W)
  ) u_row_skew (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_valid_reg),
    .in_idx    (issue_idx_reg),
    .tap_valid (row_valid),
    .tap_idx   (row_idx)
  );

  // Results leave the last row one hop after its if_en, then skew by column.
  systolic_ctrl_skew_line #(
    .N (SYS_COLS),
    .W (VEC_W)
  ) u_col_skew (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (row_valid[SYS_ROWS-1]),
    .in_idx    (row_idx[SYS_ROWS-1]),
    .tap_valid (col_valid),
    .tap_idx   (col_idx)
  );

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.w_rd_en   = w_rd_en_reg;
  assign bus.w_rd_addr = w_rd_addr_reg;
  assign bus.wfetch    = {SYS_COLS{wfetch_reg}};
  assign bus.switch    = switch_reg;
  assign bus.a_rd_en   = {row_valid[SYS_ROWS-2:0], issue_valid_reg};
  assign bus.a_rd_addr = {row_idx[SYS_ROWS-2:0], issue_idx_reg};
  assign bus.if_en     = row_valid;
  assign bus.o_valid   = col_valid;
  assign bus.o_addr    = col_idx;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: directed job scenarios plus random traffic, each
// cycle compared with a timeline model derived from the job parameters.
module tb_systolic_ctrl;
  import systolic_ctrl_pkg::*;

  localparam int R  = SYS_ROWS;
  localparam int C  = SYS_COLS;
  localparam int OL = SYS_ROWS;

  logic clk;
  logic rst;
  systolic_ctrl_if bus();

  systolic_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model of the single job in flight.
  bit job_active = 0;
  int js         = 0;
  int jnv        = 0;
  bit jreuse     = 0;

  int n_ifen [R];
  int n_ov   [C];
  int last_oaddr [C];
  int n_done = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int stream_start();
    return jreuse ? js + 1 : js + 1 + R + 2;
  endfunction

  function automatic int job_end();
    if (jnv == 0) return js + 2;
    return stream_start() + 1 + (jnv - 1) + (C - 1) + OL + 1;
  endfunction

  task automatic check_outputs();
    int t, L, S, T0, D, base;
    logic e_busy, e_done, e_wen, e_sw, e_wf;
    logic [WADDR_W-1:0] e_waddr, o_waddr;
    logic [R-1:0] e_aen, e_ifen;
    logic [R-1:0][7:0] e_aaddr, o_aaddr;
    logic [C-1:0] e_ov;
    logic [C-1:0][7:0] e_oaddr, o_oaddr;
    t = cyc;
    e_busy = 0; e_done = 0; e_wen = 0; e_sw = 0; e_wf = 0; e_waddr = '0;
    e_aen = '0; e_ifen = '0; e_aaddr = '0; e_ov = '0; e_oaddr = '0;
    if (job_active) begin
      D = job_end();
      e_busy = (t >= js + 1) && (t <= D);
      e_done = (t == D);
      if (jnv != 0) begin
        L  = js + 1;
        S  = stream_start();
        T0 = S + 1;
        if (!jreuse) begin
          if (t >= L && t <= L + R - 1) begin
            e_wen   = 1'b1;
            e_waddr = WADDR_W'(R - 1 - (t - L));
          end
          e_wf = (t >= L + 1) && (t <= L + R);
          e_sw = (t == L + R + 1);
        end
        for (int r = 0; r < R; r++) begin
          if (t >= S + r && t <= S + r + jnv - 1) begin
            e_aen[r]   = 1'b1;
            e_aaddr[r] = 8'(t - S - r);
          end
          e_ifen[r] = (t >= S + r + 1) && (t <= S + r + jnv);
        end
        for (int j = 0; j < C; j++) begin
          base = T0 + j + OL;
          if (t >= base && t < base + jnv) begin
            e_ov[j]    = 1'b1;
            e_oaddr[j] = 8'(t - base);
          end
        end
      end
    end
    o_waddr = e_wen ? bus.w_rd_addr : '0;
    for (int r = 0; r < R; r++) o_aaddr[r] = e_aen[r] ? bus.a_rd_addr[r] : 8'h0;
    for (int j = 0; j < C; j++) o_oaddr[j] = e_ov[j] ? bus.o_addr[j] : 8'h0;
    check("busy_done_wen_sw", 64'({bus.busy, bus.done, bus.w_rd_en, bus.switch}),
          64'({e_busy, e_done, e_wen, e_sw}));
    check("w_rd_addr", 64'(o_waddr), 64'(e_waddr));
    check("wfetch", 64'(bus.wfetch), 64'({C{e_wf}}));
    check("a_rd_en", 64'(bus.a_rd_en), 64'(e_aen));
    check("a_rd_addr", 64'(o_aaddr), 64'(e_aaddr));
    check("if_en", 64'(bus.if_en), 64'(e_ifen));
    check("o_valid", 64'(bus.o_valid), 64'(e_ov));
    check("o_addr", 64'(o_oaddr), 64'(e_oaddr));
  endtask

  task automatic run_cycle(input logic st, input logic [7:0] nv, input logic rw, input logic rs);
    rst         = rs;
    bus.start   = st;
    bus.num_vec = nv;
    bus.reuse_w = rw;
    @(negedge clk);
    check_outputs();
    for (int r = 0; r < R; r++) if (bus.if_en[r]) n_ifen[r]++;
    for (int j = 0; j < C; j++) begin
      if (bus.o_valid[j]) begin
        n_ov[j]++;
        last_oaddr[j] = int'(bus.o_addr[j]);
      end
    end
    if (bus.done) n_done++;
    @(posedge clk);
    if (rs) begin
      job_active = 0;
    end else if (st && (!job_active || cyc > job_end())) begin
      job_active = 1;
      js         = cyc;
      jnv        = int'(nv);
      jreuse     = rw;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    for (int r = 0; r < R; r++) n_ifen[r] = 0;
    for (int j = 0; j < C; j++) begin
      n_ov[j] = 0;
      last_oaddr[j] = -1;
    end
    n_done = 0;
  endtask

  initial begin
    logic st, rw, rs;
    logic [7:0] nv;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_vec = '0;
    bus.reuse_w = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 8'd0, 1'b0, 1'b1);
    idle(2);

    // Basic job with weight load.
    clear_counts();
    run_cycle(1'b1, 8'd3, 1'b0, 1'b0);
    idle(24);
    check("s1_done_count", 64'(n_done), 64'd1);
    $display("[TB] scenario basic: done pulses %0d", n_done);

    // Weight reuse, single vector.
    run_cycle(1'b1, 8'd1, 1'b1, 1'b0);
    idle(15);

    // Empty job.
    run_cycle(1'b1, 8'd0, 1'b0, 1'b0);
    idle(4);

    // start held high across and beyond the first job.
    for (int i = 0; i < 22; i++) run_cycle(1'b1, 8'd3, 1'b0, 1'b0);
    idle(24);

    // Abort mid-job, then a clean job.
    clear_counts();
    run_cycle(1'b1, 8'd3, 1'b0, 1'b0);
    idle(8);
    run_cycle(1'b0, 8'd0, 1'b0, 1'b1);
    idle(2);
    run_cycle(1'b1, 8'd3, 1'b0, 1'b0);
    idle(24);
    check("s5_done_count", 64'(n_done), 64'd1);
    $display("[TB] scenario abort: done pulses %0d", n_done);

    // Maximum-length job.
    clear_counts();
    run_cycle(1'b1, 8'd255, 1'b0, 1'b0);
    idle(290);
    for (int r = 0; r < R; r++) check("s6_if_en_count", 64'(n_ifen[r]), 64'd255);
    for (int j = 0; j < C; j++) check("s6_o_valid_count", 64'(n_ov[j]), 64'd255);
    check("s6_last_o_addr", 64'(last_oaddr[C-1]), 64'd254);
    check("s6_done_count", 64'(n_done), 64'd1);
    $display("[TB] scenario max: last o_addr %0d", last_oaddr[C-1]);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      st = ($urandom_range(0, 7) == 0);
      rw = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 19) == 0) nv = 8'($urandom_range(0, 255));
      else nv = 8'($urandom_range(0, 12));
      run_cycle(st, nv, rw, rs);
    end
    idle(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
